// File: rtl/servant_ram_arbiter.sv
// Two-master to one-slave Wishbone classic arbiter for a shared servant RAM.
// Round-robin registered grant held for a whole transfer, with a per-transfer watchdog.
module servant_ram_arbiter #(
    parameter int aw      = 10,
    parameter int TIMEOUT = 16
) (
    input  logic          i_wb_clk,
    input  logic          i_wb_rst,
    input  logic [aw-3:0] i_m0_adr,
    input  logic [31:0]   i_m0_dat,
    input  logic [3:0]    i_m0_sel,
    input  logic          i_m0_we,
    input  logic          i_m0_cyc,
    output logic [31:0]   o_m0_rdt,
    output logic          o_m0_ack,
    output logic          o_m0_err,
    input  logic [aw-3:0] i_m1_adr,
    input  logic [31:0]   i_m1_dat,
    input  logic [3:0]    i_m1_sel,
    input  logic          i_m1_we,
    input  logic          i_m1_cyc,
    output logic [31:0]   o_m1_rdt,
    output logic          o_m1_ack,
    output logic          o_m1_err,
    output logic [aw-3:0] o_s_adr,
    output logic [31:0]   o_s_dat,
    output logic [3:0]    o_s_sel,
    output logic          o_s_we,
    output logic          o_s_cyc,
    input  logic [31:0]   i_s_rdt,
    input  logic          i_s_ack,
    output logic          o_grant,
    output logic          o_busy
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_gnt, w_gnt_nxt;
    logic          r_last, w_last_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    logic w_busy, w_cyc_g, w_ack, w_err, w_done;

    // Handshake: a master requests by raising cyc and holds it (with stable adr/dat/sel/we)
    // until it sees ack or err; dropping cyc early aborts and any late slave ack is discarded.
    assign w_busy  = (r_state == BUSY);
    assign w_cyc_g = r_gnt ? i_m1_cyc : i_m0_cyc;
    assign w_ack   = w_busy & w_cyc_g & i_s_ack;
    assign w_err   = (TIMEOUT > 0) && w_busy && w_cyc_g && !i_s_ack && (r_cnt == CNT_LAST);
    assign w_done  = !w_cyc_g | w_ack | w_err;

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            r_state <= IDLE;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (i_m0_cyc | i_m1_cyc) begin
                    w_state_nxt = BUSY;
                    // Under contention the master that did not finish last wins.
                    w_gnt_nxt   = (i_m0_cyc & i_m1_cyc) ? ~r_last : i_m1_cyc;
                    w_cnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (w_done) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = r_gnt;
                end else if (TIMEOUT > 0) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_s_adr = w_busy ? (r_gnt ? i_m1_adr : i_m0_adr) : '0;
    assign o_s_dat = w_busy ? (r_gnt ? i_m1_dat : i_m0_dat) : '0;
    assign o_s_sel = w_busy ? (r_gnt ? i_m1_sel : i_m0_sel) : '0;
    assign o_s_we  = w_busy & (r_gnt ? i_m1_we : i_m0_we);
    assign o_s_cyc = w_busy & w_cyc_g;

    assign o_m0_rdt = (w_busy & ~r_gnt) ? i_s_rdt : '0;
    assign o_m1_rdt = (w_busy &  r_gnt) ? i_s_rdt : '0;
    assign o_m0_ack = w_ack & ~r_gnt;
    assign o_m1_ack = w_ack &  r_gnt;
    assign o_m0_err = w_err & ~r_gnt;
    assign o_m1_err = w_err &  r_gnt;

    assign o_grant = r_gnt;
    assign o_busy  = w_busy;

endmodule

// File: doc/servant_ram_arbiter.md
Name: servant_ram_arbiter

Overview:
- Two-master to one-slave Wishbone (classic, single-beat) arbiter that shares one servant RAM instance between master 0 (CPU bus) and master 1 (debug/loader bus).
- Registered round-robin grant, held for the whole transfer.
- Per-transfer watchdog terminates hung transfers with an error strobe.
- Sits between the masters and the RAM; the RAM acks one cycle after it samples cyc.

Parameters:
- aw, 10, byte-address width of the RAM; word address is [aw-1:2].
- TIMEOUT, 16, maximum cycles spent in BUSY waiting for slave ack. 0 disables the watchdog.

Ports:
- i_wb_clk  in  1  clock
- i_wb_rst  in  1  reset, asynchronous, active-high
- i_m0_adr  in  aw-2  master 0 word address
- i_m0_dat  in  32  master 0 write data
- i_m0_sel  in  4  master 0 byte enables
- i_m0_we  in  1  master 0 write enable
- i_m0_cyc  in  1  master 0 request/cycle
- o_m0_rdt  out  32  master 0 read data
- o_m0_ack  out  1  master 0 acknowledge
- o_m0_err  out  1  master 0 timeout error
- i_m1_adr, i_m1_dat, i_m1_sel, i_m1_we, i_m1_cyc, o_m1_rdt, o_m1_ack, o_m1_err: same as master 0, for master 1
- o_s_adr  out  aw-2  slave word address
- o_s_dat  out  32  slave write data
- o_s_sel  out  4  slave byte enables
- o_s_we  out  1  slave write enable
- o_s_cyc  out  1  slave cycle
- i_s_rdt  in  32  slave read data
- i_s_ack  in  1  slave acknowledge
- o_grant  out  1  index of the current or last granted master
- o_busy  out  1  arbiter in BUSY

Behaviour:
- Registers: state {IDLE, BUSY}, gnt (1b), last (1b), cnt ($clog2(TIMEOUT+1) bits).
- Async reset sets: state=IDLE, gnt=0, last=1 (so m0 wins the first contention), cnt=0. All outputs are 0 during reset.
- IDLE:
  - If exactly one cyc is high, grant that master.
  - If both are high, grant !last.
  - On the next edge: state=BUSY, gnt=winner, cnt=0.
  - If no cyc is high, stay in IDLE.
- BUSY:
  - o_s_* is muxed combinationally from master gnt, and o_s_cyc = cyc of master gnt.
  - Outside BUSY, o_s_adr/dat/sel/we/cyc are all 0.
  - o_mX_rdt = i_s_rdt for X==gnt, else 0.
- Ack forwarding: o_mX_ack = BUSY & gnt==X & i_s_ack & i_mX_cyc. Registered edge on ack: state=IDLE, last=gnt.
- Abort: granted master cyc low in BUSY means no ack/err is forwarded that cycle, and at the next edge state=IDLE, last=gnt.
- Watchdog (TIMEOUT>0):
  - cnt increments each BUSY cycle without ack.
  - o_mX_err = BUSY & gnt==X & cyc & !i_s_ack & cnt==TIMEOUT-1, as a single-cycle strobe.
  - The next edge goes to IDLE, last=gnt.
  - ack and err are never asserted together.
- i_s_ack outside BUSY, or with the granted cyc low, is ignored. This covers stale RAM acks after an abort.
- The non-granted master sees ack=0 and err=0 and waits with cyc held. No starvation: after any completion the other waiting master wins next.
- Latency with the RAM: cyc rises at cycle 0, BUSY from cycle 1, ack in cycle 2, IDLE in cycle 3. Minimum spacing between grants is 3 cycles.
- o_busy = (state==BUSY). o_grant = gnt.
- Reset asserted mid-transfer forces IDLE immediately; no ack is forwarded.

Test Plan:
- Single m0 write: adr=5, dat=32'hDEADBEEF, sel=4'hF, cyc held.
  - o_s_cyc is high in cycle 1 and o_m0_ack in cycle 2.
  - A subsequent m0 read of adr=5 returns o_m0_rdt=32'hDEADBEEF with ack at cycle 2.
- Simultaneous m0/m1 requests from reset:
  - m0 is granted first and m1 second.
  - Holding both requests repeatedly alternates grants 0,1,0,1 and o_grant tracks.
- Byte write from m1: sel=4'b0100, dat=32'h00AB0000 to a word preloaded with 32'h11223344. Readback = 32'h11AB3344.
- Slave never acks (i_s_ack tied 0), TIMEOUT=16: o_m0_err pulses exactly one cycle, 16 cycles after BUSY entry. Then o_busy=0 and o_s_cyc=0.
- Abort: m1 drops cyc in its first BUSY cycle.
  - No o_m1_ack.
  - The stale RAM ack the following cycle is not forwarded to m0 or m1.
  - A pending m0 is granted next.
- Async reset pulse mid-BUSY: all outputs drop to 0 without a clock edge. After release, o_grant=0 and the first request is served normally.
